// File: rtl/skewed_address_generator_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : agen_pkg
// Description : Shared constants and FSM encoding for the skewed address
//               generator and its lanes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package agen_pkg;

   // Lane base selection: shared base or base + n*row_stride
   localparam logic MODE_SHARED  = 1'b0;
   localparam logic MODE_STRIDED = 1'b1;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } agen_state_t;

endpackage
`default_nettype wire

// File: rtl/skewed_address_generator_lane.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : agen_lane
// Description : One operand-buffer lane. Delays the enable from the previous
//               lane by one cycle, counts the per-transfer offset and adds it
//               to the lane base latched when the descriptor is accepted.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module agen_lane
   import agen_pkg::*;
#(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] base_in,
   input  logic                  en_in,
   output logic                  en_chain,
   output logic                  enable,
   output logic [ADDR_WIDTH-1:0] address
);

   logic                  r_en;
   logic [ADDR_WIDTH-1:0] r_off;
   logic [ADDR_WIDTH-1:0] r_base;

   // Skew register, offset counter and lane base; everything freezes on stall
   always_ff @(posedge clk) begin
      if (reset) begin
         r_en   <= 1'b0;
         r_off  <= '0;
         r_base <= '0;
      end else if (!stall) begin
         if (load) begin
            r_base <= base_in;
         end
         r_en  <= en_in;
         // Offset is 0 in the first enabled cycle and steps once per issue
         r_off <= r_en ? r_off + ADDR_WIDTH'(1) : '0;
      end
   end

   // The raw enable feeds the next lane so a stall does not break the skew
   assign en_chain = r_en;

   // Stall masks the read enable in the same cycle it is raised
   assign enable   = r_en & ~stall;

   // Address is a sum of registers only; idle lanes present zero
   assign address  = r_en ? (r_base + r_off) : '0;

endmodule
`default_nettype wire

// File: rtl/skewed_address_generator.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : skewed_address_generator
// Description : Accepts one transfer descriptor and drives ARRAY_N operand
//               buffer lanes with diagonally skewed read enables and
//               per-lane incrementing addresses. Signals its own completion.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module skewed_address_generator
   import agen_pkg::*;
#(
   parameter int ADDR_WIDTH        = 16,
   parameter int ARRAY_N           = 8,
   parameter int LEN_WIDTH         = 16,
   parameter int CONCAT_ADDR_WIDTH = ADDR_WIDTH * ARRAY_N
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cfg_valid,
   output logic                         cfg_ready,
   input  logic [ADDR_WIDTH-1:0]        cfg_base_addr,
   input  logic [LEN_WIDTH-1:0]         cfg_length,
   input  logic [$clog2(ARRAY_N):0]     cfg_num_rows,
   input  logic                         cfg_mode,
   input  logic [ADDR_WIDTH-1:0]        cfg_row_stride,
   input  logic                         stall,
   output logic [CONCAT_ADDR_WIDTH-1:0] address,
   output logic [ARRAY_N-1:0]           enable,
   output logic                         busy,
   output logic                         done
);

   localparam int ROW_W = $clog2(ARRAY_N) + 1;

   agen_state_t          r_state;
   agen_state_t          w_state_next;
   logic [LEN_WIDTH-1:0] r_len;
   logic [LEN_WIDTH-1:0] r_cnt;
   logic [LEN_WIDTH-1:0] w_cnt_next;
   logic [ROW_W-1:0]     r_rows;
   logic [ROW_W-1:0]     r_drain;
   logic [ROW_W-1:0]     w_drain_next;
   logic                 r_done;
   logic                 w_done_next;
   logic                 w_issue;
   logic                 w_accept;
   logic [ROW_W-1:0]     w_rows_eff;
   logic [ADDR_WIDTH-1:0] w_step;
   logic [ARRAY_N-1:0]   w_lane_en_in;
   logic [ARRAY_N-1:0]   w_lane_chain;

   // Requested rows beyond the physical array are clamped to ARRAY_N
   assign w_rows_eff = (cfg_num_rows > ROW_W'(ARRAY_N)) ? ROW_W'(ARRAY_N) : cfg_num_rows;

   // Per-row base increment; zero in shared mode so every lane starts at base
   assign w_step     = (cfg_mode == MODE_STRIDED) ? cfg_row_stride : '0;

   // Descriptors are only taken while idle and not frozen
   assign cfg_ready  = (r_state == ST_IDLE) & ~stall;
   assign w_accept   = cfg_valid & cfg_ready;
   assign busy       = (r_state != ST_IDLE);
   assign done       = r_done;

   // Descriptor registers: transfer length and clamped row count
   always_ff @(posedge clk) begin
      if (reset) begin
         r_len  <= '0;
         r_rows <= '0;
      end else if (w_accept) begin
         r_len  <= cfg_length;
         r_rows <= w_rows_eff;
      end
   end

   // FSM state, issue counter, drain counter and done pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_drain <= '0;
         r_done  <= 1'b0;
      end else if (stall) begin
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_drain <= w_drain_next;
         r_done  <= w_done_next;
      end
   end

   // Next-state logic; w_issue requests a lane-0 issue in the following cycle
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_drain_next = r_drain;
      w_done_next  = 1'b0;
      w_issue      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if ((cfg_length == '0) || (w_rows_eff == '0)) begin
                  w_done_next = 1'b1;
               end else begin
                  w_issue      = 1'b1;
                  w_cnt_next   = '0;
                  w_state_next = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            // r_cnt is the index of the issue lane 0 performs this cycle
            if (r_cnt == (r_len - LEN_WIDTH'(1))) begin
               if (r_rows == ROW_W'(1)) begin
                  w_done_next  = 1'b1;
                  w_state_next = ST_IDLE;
               end else begin
                  w_drain_next = r_rows - ROW_W'(2);
                  w_state_next = ST_DRAIN;
               end
            end else begin
               w_issue    = 1'b1;
               w_cnt_next = r_cnt + LEN_WIDTH'(1);
            end
         end
         ST_DRAIN: begin
            if (r_drain == '0) begin
               w_done_next  = 1'b1;
               w_state_next = ST_IDLE;
            end else begin
               w_drain_next = r_drain - ROW_W'(1);
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   for (genvar n = 0; n < ARRAY_N; n++) begin : g_lane
      logic [ADDR_WIDTH-1:0] w_base;

      if (n == 0) begin : g_head
         assign w_base          = cfg_base_addr;
         assign w_lane_en_in[n] = w_issue;
      end else begin : g_tail
         logic r_act;

         // Lane participation flag, captured with the descriptor
         always_ff @(posedge clk) begin
            if (reset) begin
               r_act <= 1'b0;
            end else if (w_accept) begin
               r_act <= (ROW_W'(n) < w_rows_eff);
            end
         end

         // Constant-coefficient product evaluated only at latch time
         assign w_base          = cfg_base_addr + (ADDR_WIDTH'(n) * w_step);
         assign w_lane_en_in[n] = w_lane_chain[n-1] & r_act;
      end

      agen_lane #(
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .stall    (stall),
         .load     (w_accept),
         .base_in  (w_base),
         .en_in    (w_lane_en_in[n]),
         .en_chain (w_lane_chain[n]),
         .enable   (enable[n]),
         .address  (address[n*ADDR_WIDTH +: ADDR_WIDTH])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_skewed_address_generator.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_skewed_address_generator
// Description : Directed self-checking bench for skewed_address_generator.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_skewed_address_generator;

   localparam int AW = 16;
   localparam int N  = 8;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [AW-1:0] cfg_base_addr;
   logic [LW-1:0] cfg_length;
   logic [3:0]    cfg_num_rows;
   logic          cfg_mode;
   logic [AW-1:0] cfg_row_stride;
   logic          stall;
   logic [AW*N-1:0] address;
   logic [N-1:0]  enable;
   logic          busy;
   logic          done;

   int checks   = 0;
   int failures = 0;

   logic [15:0] cap [N][16];
   int          cap_cnt [N];

   always #5 clk = ~clk;

   skewed_address_generator #(
      .ADDR_WIDTH (AW),
      .ARRAY_N    (N),
      .LEN_WIDTH  (LW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .cfg_valid      (cfg_valid),
      .cfg_ready      (cfg_ready),
      .cfg_base_addr  (cfg_base_addr),
      .cfg_length     (cfg_length),
      .cfg_num_rows   (cfg_num_rows),
      .cfg_mode       (cfg_mode),
      .cfg_row_stride (cfg_row_stride),
      .stall          (stall),
      .address        (address),
      .enable         (enable),
      .busy           (busy),
      .done           (done)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] lane_addr(input int n);
      return address[n*16 +: 16];
   endfunction

   // Offer one descriptor, then walk every cycle against the timing formulas
   task automatic run_xfer(input logic [15:0] base, input logic [15:0] len,
                           input logic [3:0] rows, input logic mode,
                           input logic [15:0] stride, input int s_start, input int s_len);
      int          reff;
      int          total;
      int          e;
      logic        stl;
      logic        degen;
      logic        ready_exp;
      logic [7:0]  exp_en;
      logic [15:0] exp_a;
      for (int n = 0; n < N; n++) cap_cnt[n] = 0;
      reff  = (rows > 4'd8) ? 8 : int'(rows);
      degen = (len == 16'd0) || (reff == 0);
      total = degen ? 1 : int'(len) + reff + s_len;
      cfg_base_addr  = base;
      cfg_length     = len;
      cfg_num_rows   = rows;
      cfg_mode       = mode;
      cfg_row_stride = stride;
      cfg_valid      = 1'b1;
      #1;
      check_eq("hs_ready", cfg_ready, 1'b1);
      tick();
      cfg_valid = 1'b0;
      for (int c = 1; c <= total + 1; c++) begin
         stl   = (s_len > 0) && (c >= s_start) && (c < s_start + s_len);
         stall = stl;
         #1;
         e = (s_len > 0 && c >= s_start + s_len) ? c - s_len : c;
         exp_en = '0;
         for (int n = 0; n < N; n++)
            if (!stl && !degen && n < reff && e >= 1 + n && e <= int'(len) + n) exp_en[n] = 1'b1;
         check_eq($sformatf("en c%0d", c), enable, exp_en);
         for (int n = 0; n < N; n++) begin
            if (exp_en[n]) begin
               exp_a = base + (mode ? 16'(n) * stride : 16'h0) + 16'(e - 1 - n);
               check_eq($sformatf("addr c%0d l%0d", c, n), lane_addr(n), exp_a);
            end else if (n >= reff) begin
               check_eq($sformatf("addr0 c%0d l%0d", c, n), lane_addr(n), 16'h0);
            end
            if (enable[n] && cap_cnt[n] < 16) begin
               cap[n][cap_cnt[n]] = lane_addr(n);
               cap_cnt[n]++;
            end
         end
         check_eq($sformatf("done c%0d", c), done,
                  !stl && (degen ? (c == 1) : (e == int'(len) + reff)));
         if (!stl) begin
            ready_exp = degen ? 1'b1 : (e >= int'(len) + reff);
            check_eq($sformatf("ready c%0d", c), cfg_ready, ready_exp);
            check_eq($sformatf("busy c%0d", c), busy, !ready_exp);
         end
         tick();
      end
      stall = 1'b0;
   endtask

   logic [15:0] wrap_exp [4];
   logic        exp_b;

   initial begin
      reset          = 1'b1;
      cfg_valid      = 1'b0;
      cfg_base_addr  = '0;
      cfg_length     = '0;
      cfg_num_rows   = '0;
      cfg_mode       = 1'b0;
      cfg_row_stride = '0;
      stall          = 1'b0;
      wrap_exp       = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      repeat (3) tick();

      // Reset values
      check_eq("rst_ready", cfg_ready, 1'b1);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_en", enable, 8'h0);
      check_eq("rst_addr", |address, 1'b0);
      reset = 1'b0;
      tick();

      // Shared mode, full array
      run_xfer(16'h0100, 16'd4, 4'd8, 1'b0, 16'h0, 0, 0);
      check_eq("sh_l3_cnt", cap_cnt[3], 4);
      for (int i = 0; i < 4; i++) check_eq($sformatf("sh_l3_%0d", i), cap[3][i], 16'h0100 + 16'(i));

      // Strided mode, three rows
      run_xfer(16'h0040, 16'd2, 4'd3, 1'b1, 16'h0010, 0, 0);
      check_eq("st_l2_0", cap[2][0], 16'h0060);
      check_eq("st_l2_1", cap[2][1], 16'h0061);
      check_eq("st_l3_cnt", cap_cnt[3], 0);

      // Zero length
      run_xfer(16'h0010, 16'd0, 4'd4, 1'b0, 16'h0, 0, 0);
      check_eq("l0_cnt", cap_cnt[0], 0);

      // Row count clamps to the array size
      run_xfer(16'h0800, 16'd2, 4'd12, 1'b1, 16'h0100, 0, 0);
      check_eq("clamp_l7_cnt", cap_cnt[7], 2);
      check_eq("clamp_l7_0", cap[7][0], 16'h0F00);
      check_eq("clamp_l7_1", cap[7][1], 16'h0F01);

      // Address wrap-around
      run_xfer(16'hFFFE, 16'd4, 4'd1, 1'b0, 16'h0, 0, 0);
      for (int i = 0; i < 4; i++) check_eq($sformatf("wrap_%0d", i), cap[0][i], wrap_exp[i]);

      // Three-cycle stall during RUN
      run_xfer(16'h0500, 16'd5, 4'd2, 1'b0, 16'h0, 3, 3);
      check_eq("stall_l0_cnt", cap_cnt[0], 5);
      check_eq("stall_l1_cnt", cap_cnt[1], 5);
      for (int i = 0; i < 5; i++) begin
         check_eq($sformatf("stall_l0_%0d", i), cap[0][i], 16'h0500 + 16'(i));
         check_eq($sformatf("stall_l1_%0d", i), cap[1][i], 16'h0500 + 16'(i));
      end

      // Reset in the middle of RUN
      cfg_base_addr = 16'h0700;
      cfg_length    = 16'd6;
      cfg_num_rows  = 4'd4;
      cfg_mode      = 1'b0;
      cfg_valid     = 1'b1;
      tick();
      cfg_valid = 1'b0;
      tick();
      tick();
      check_eq("mr_busy_pre", busy, 1'b1);
      reset = 1'b1;
      tick();
      check_eq("mr_ready", cfg_ready, 1'b1);
      check_eq("mr_busy", busy, 1'b0);
      check_eq("mr_done", done, 1'b0);
      check_eq("mr_en", enable, 8'h0);
      check_eq("mr_addr", |address, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check_eq($sformatf("mr_nodone_%0d", i), done, 1'b0);
         tick();
      end
      run_xfer(16'h0900, 16'd3, 4'd2, 1'b1, 16'h0004, 0, 0);

      // Back-to-back: second descriptor waits and is taken in the done cycle
      cfg_base_addr = 16'h0200;
      cfg_length    = 16'd3;
      cfg_num_rows  = 4'd2;
      cfg_mode      = 1'b0;
      cfg_valid     = 1'b1;
      tick();
      cfg_base_addr = 16'h0300;
      cfg_length    = 16'd2;
      cfg_num_rows  = 4'd1;
      for (int c = 1; c <= 9; c++) begin
         #1;
         exp_b = (c >= 1 && c <= 3) || (c >= 6 && c <= 7);
         check_eq($sformatf("bb_en0 c%0d", c), enable[0], exp_b);
         if (exp_b)
            check_eq($sformatf("bb_a0 c%0d", c), lane_addr(0),
                     (c <= 3) ? 16'h0200 + 16'(c - 1) : 16'h0300 + 16'(c - 6));
         check_eq($sformatf("bb_en1 c%0d", c), enable[1], (c >= 2 && c <= 4));
         check_eq($sformatf("bb_done c%0d", c), done, (c == 5 || c == 8));
         check_eq($sformatf("bb_ready c%0d", c), cfg_ready, (c == 5 || c >= 8));
         tick();
         if (c == 5) cfg_valid = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
